jtbubl_snd_mailbox: RTL

JTBUBL_SND_MAILBOX -- requirements
Module: jtbubl_snd_mailbox

---
 rtl/jtbubl_snd_mailbox.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/jtbubl_snd_mailbox.sv
// Bidirectional main/sound CPU mailbox: two show-ahead FIFOs with sticky overflow flags,
// a sound-side register map with edge-detected accesses, and an NMI request to the sound CPU.
module jtbubl_snd_mailbox #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          main_wr,
    input  logic [DW-1:0] main_din,
    input  logic          main_rd,
    output logic [DW-1:0] main_dout,
    output logic          main_pending,
    output logic          main_full,
    input  logic          snd_cs,
    input  logic          snd_rd_n,
    input  logic          snd_wr_n,
    input  logic [1:0]    snd_addr,
    input  logic [DW-1:0] snd_din,
    output logic [DW-1:0] snd_dout,
    output logic          nmi_n
);

    localparam int unsigned   DEPTH    = 1 << AW;
    localparam int unsigned   CW       = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [DW-1:0] ONES     = '1;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_NMIOFF = 2'd2;
    localparam logic [1:0] A_FLUSH  = 2'd3;

    // Sound access edge detection
    logic rd_act_c;
    logic wr_act_c;
    logic rd_start_c;
    logic wr_start_c;
    logic rd_prev_q;
    logic wr_prev_q;

    // Decoded sound actions
    logic m2s_pop_c;
    logic s2m_push_c;
    logic stat_rd_c;
    logic nmi_set_c;
    logic nmi_clr_c;
    logic flush_c;

    // Main-to-sound FIFO
    logic [DW-1:0] m2s_mem_q [DEPTH];
    logic [AW-1:0] m2s_wp_q;
    logic [AW-1:0] m2s_wp_d;
    logic [AW-1:0] m2s_rp_q;
    logic [AW-1:0] m2s_rp_d;
    logic [CW-1:0] m2s_cnt_q;
    logic [CW-1:0] m2s_cnt_d;
    logic          m2s_ovf_q;
    logic          m2s_ovf_d;
    logic          m2s_do_pop_c;
    logic          m2s_do_push_c;
    logic          m2s_empty_c;
    logic [DW-1:0] m2s_head_c;

    // Sound-to-main FIFO
    logic [DW-1:0] s2m_mem_q [DEPTH];
    logic [AW-1:0] s2m_wp_q;
    logic [AW-1:0] s2m_wp_d;
    logic [AW-1:0] s2m_rp_q;
    logic [AW-1:0] s2m_rp_d;
    logic [CW-1:0] s2m_cnt_q;
    logic [CW-1:0] s2m_cnt_d;
    logic          s2m_ovf_q;
    logic          s2m_ovf_d;
    logic          s2m_do_pop_c;
    logic          s2m_do_push_c;
    logic          s2m_empty_c;

    // Control and sound-side read path
    logic          nmi_en_q;
    logic          nmi_en_d;
    logic          nmi_n_q;
    logic          nmi_n_d;
    logic [DW-1:0] snd_dout_q;
    logic [DW-1:0] snd_dout_d;
    logic [DW-1:0] status_c;

    assign rd_act_c   = snd_cs & ~snd_rd_n;
    assign wr_act_c   = snd_cs & ~snd_wr_n;
    assign rd_start_c = rd_act_c & ~rd_prev_q;
    assign wr_start_c = wr_act_c & ~wr_prev_q;

    assign m2s_pop_c  = rd_start_c && (snd_addr == A_DATA);
    assign stat_rd_c  = rd_start_c && (snd_addr == A_STATUS);
    assign s2m_push_c = wr_start_c && (snd_addr == A_DATA);
    assign nmi_set_c  = wr_start_c && (snd_addr == A_STATUS);
    assign nmi_clr_c  = wr_start_c && (snd_addr == A_NMIOFF);
    assign flush_c    = wr_start_c && (snd_addr == A_FLUSH);

    assign m2s_empty_c = (m2s_cnt_q == '0);
    assign s2m_empty_c = (s2m_cnt_q == '0);

    // m2s next state: a pop frees a slot before the push is judged, flush overrides all
    always_comb begin
        m2s_do_pop_c  = m2s_pop_c && !m2s_empty_c;
        m2s_do_push_c = main_wr && ((m2s_cnt_q != CNT_FULL) || m2s_do_pop_c);
        m2s_head_c    = m2s_empty_c ? ONES : m2s_mem_q[m2s_rp_q];
        m2s_wp_d      = m2s_wp_q;
        m2s_rp_d      = m2s_rp_q;
        m2s_cnt_d     = m2s_cnt_q;
        m2s_ovf_d     = m2s_ovf_q;
        if (flush_c) begin
            m2s_wp_d  = '0;
            m2s_rp_d  = '0;
            m2s_cnt_d = '0;
            m2s_ovf_d = 1'b0;
        end else begin
            if (m2s_do_pop_c) begin
                m2s_rp_d = m2s_rp_q + AW'(1);
            end
            if (m2s_do_push_c) begin
                m2s_wp_d = m2s_wp_q + AW'(1);
            end
            case ({m2s_do_push_c, m2s_do_pop_c})
                2'b10:   m2s_cnt_d = m2s_cnt_q + CW'(1);
                2'b01:   m2s_cnt_d = m2s_cnt_q - CW'(1);
                default: m2s_cnt_d = m2s_cnt_q;
            endcase
            if (stat_rd_c) begin
                m2s_ovf_d = 1'b0;
            end
            if (main_wr && !m2s_do_push_c) begin
                m2s_ovf_d = 1'b1;
            end
        end
    end

    // s2m next state: same rules, pushed by the sound CPU, popped by the main CPU
    always_comb begin
        s2m_do_pop_c  = main_rd && !s2m_empty_c;
        s2m_do_push_c = s2m_push_c && ((s2m_cnt_q != CNT_FULL) || s2m_do_pop_c);
        s2m_wp_d      = s2m_wp_q;
        s2m_rp_d      = s2m_rp_q;
        s2m_cnt_d     = s2m_cnt_q;
        s2m_ovf_d     = s2m_ovf_q;
        if (flush_c) begin
            s2m_wp_d  = '0;
            s2m_rp_d  = '0;
            s2m_cnt_d = '0;
            s2m_ovf_d = 1'b0;
        end else begin
            if (s2m_do_pop_c) begin
                s2m_rp_d = s2m_rp_q + AW'(1);
            end
            if (s2m_do_push_c) begin
                s2m_wp_d = s2m_wp_q + AW'(1);
            end
            case ({s2m_do_push_c, s2m_do_pop_c})
                2'b10:   s2m_cnt_d = s2m_cnt_q + CW'(1);
                2'b01:   s2m_cnt_d = s2m_cnt_q - CW'(1);
                default: s2m_cnt_d = s2m_cnt_q;
            endcase
            if (stat_rd_c) begin
                s2m_ovf_d = 1'b0;
            end
            if (s2m_push_c && !s2m_do_push_c) begin
                s2m_ovf_d = 1'b1;
            end
        end
    end

    // Status word, unused upper bits read as ones
    always_comb begin
        status_c    = ONES;
        status_c[0] = !m2s_empty_c;
        status_c[1] = (s2m_cnt_q == CNT_FULL);
        status_c[2] = m2s_ovf_q;
        status_c[3] = nmi_en_q;
        status_c[4] = s2m_ovf_q;
    end

    // Sound read data and control registers
    always_comb begin
        snd_dout_d = snd_dout_q;
        nmi_en_d   = nmi_en_q;
        nmi_n_d    = !(nmi_en_q && !m2s_empty_c);
        if (rd_start_c) begin
            case (snd_addr)
                A_DATA:   snd_dout_d = m2s_head_c;
                A_STATUS: snd_dout_d = status_c;
                default:  snd_dout_d = ONES;
            endcase
        end
        if (nmi_set_c) begin
            nmi_en_d = 1'b1;
        end else if (nmi_clr_c) begin
            nmi_en_d = 1'b0;
        end
    end

    // Edge detectors reset high so a strobe already active at reset release is ignored
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_prev_q  <= 1'b1;
            wr_prev_q  <= 1'b1;
            m2s_wp_q   <= '0;
            m2s_rp_q   <= '0;
            m2s_cnt_q  <= '0;
            m2s_ovf_q  <= 1'b0;
            s2m_wp_q   <= '0;
            s2m_rp_q   <= '0;
            s2m_cnt_q  <= '0;
            s2m_ovf_q  <= 1'b0;
            nmi_en_q   <= 1'b0;
            nmi_n_q    <= 1'b1;
            snd_dout_q <= ONES;
        end else begin
            rd_prev_q  <= rd_act_c;
            wr_prev_q  <= wr_act_c;
            m2s_wp_q   <= m2s_wp_d;
            m2s_rp_q   <= m2s_rp_d;
            m2s_cnt_q  <= m2s_cnt_d;
            m2s_ovf_q  <= m2s_ovf_d;
            s2m_wp_q   <= s2m_wp_d;
            s2m_rp_q   <= s2m_rp_d;
            s2m_cnt_q  <= s2m_cnt_d;
            s2m_ovf_q  <= s2m_ovf_d;
            nmi_en_q   <= nmi_en_d;
            nmi_n_q    <= nmi_n_d;
            snd_dout_q <= snd_dout_d;
        end
    end

    // FIFO storage, contents are only observed while the count covers them
    always_ff @(posedge clk) begin
        if (m2s_do_push_c && !flush_c) begin
            m2s_mem_q[m2s_wp_q] <= main_din;
        end
        if (s2m_do_push_c && !flush_c) begin
            s2m_mem_q[s2m_wp_q] <= snd_din;
        end
    end

    assign main_dout    = s2m_empty_c ? ONES : s2m_mem_q[s2m_rp_q];
    assign main_pending = !s2m_empty_c;
    assign main_full    = (m2s_cnt_q == CNT_FULL);
    assign snd_dout     = snd_dout_q;
    assign nmi_n        = nmi_n_q;

endmodule
